// File: rtl/pipeline_pkg.sv
// Shared definitions for the barrel-threaded pipeline: default widths,
// opcode constants and the reset PC.
package pipeline_pkg;

  localparam int DEFAULT_THREAD_INDEX_BITS = 3;
  localparam int DEFAULT_INSTR_WIDTH       = 32;
  localparam int DEFAULT_PC_WIDTH          = 16;

  localparam int RESET_PC = 0;

  typedef enum logic [5:0] {
    OP_INCREMENT = 6'b000001,
    OP_LOAD      = 6'b000010,
    OP_STORE     = 6'b000011
  } opcode_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus plus the registered fetch outputs toward decode.
// imem_rdata is valid the cycle after imem_re and held while imem_re is low.
interface fetch_stage_if
  import pipeline_pkg::*;
#(
  parameter int INSTR_WIDTH       = DEFAULT_INSTR_WIDTH,
  parameter int THREAD_INDEX_BITS = DEFAULT_THREAD_INDEX_BITS,
  parameter int PC_WIDTH          = DEFAULT_PC_WIDTH
);

  logic [PC_WIDTH-1:0]          imem_raddr;
  logic                         imem_re;
  logic [INSTR_WIDTH-1:0]       imem_rdata;
  logic                         out_instruction_valid_flag;
  logic [INSTR_WIDTH-1:0]       out_instruction;
  logic [THREAD_INDEX_BITS-1:0] out_thread_index;

  modport master (
    output imem_raddr,
    output imem_re,
    input  imem_rdata,
    output out_instruction_valid_flag,
    output out_instruction,
    output out_thread_index
  );

  modport slave (
    input  imem_raddr,
    input  imem_re,
    output imem_rdata,
    input  out_instruction_valid_flag,
    input  out_instruction,
    input  out_thread_index
  );

endinterface

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin pick: scans last_grant+1 .. last_grant (mod N)
// and grants the first requester.
module round_robin_arbiter #(
  parameter  int N  = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  request,
  input  logic [IW-1:0] last_grant,
  output logic [IW-1:0] grant,
  output logic          any_grant
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last_grant) + k) % N);
      if (!found && request[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  assign any_grant = |request;

endmodule

// File: rtl/fetch_stage.sv
// Front stage of the barrel-threaded pipeline: per-thread PCs, round-robin
// thread pick, synchronous imem read, registered valid/thread toward decode.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int INSTR_WIDTH       = DEFAULT_INSTR_WIDTH,
  parameter int THREAD_INDEX_BITS = DEFAULT_THREAD_INDEX_BITS,
  parameter int PC_WIDTH          = DEFAULT_PC_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [(1<<THREAD_INDEX_BITS)-1:0] in_thread_enable_mask,
  input  logic                              in_stall_flag,
  input  logic                              in_redirect_flag,
  input  logic [THREAD_INDEX_BITS-1:0]      in_redirect_thread_index,
  input  logic [PC_WIDTH-1:0]               in_redirect_pc,
  fetch_stage_if.master                     bus
);

  localparam int N = 1 << THREAD_INDEX_BITS;

  logic [PC_WIDTH-1:0]          pc_q [N];
  logic [THREAD_INDEX_BITS-1:0] last_thread_q;
  logic                         valid_q;
  logic [THREAD_INDEX_BITS-1:0] thread_q;

  logic [THREAD_INDEX_BITS-1:0] sel;
  logic                         any_en;
  logic                         issue;

  round_robin_arbiter #(.N(N)) u_arbiter (
    .request    (in_thread_enable_mask),
    .last_grant (last_thread_q),
    .grant      (sel),
    .any_grant  (any_en)
  );

  // Reset outranks stall, stall outranks issue.
  assign issue = !reset && !in_stall_flag && any_en;

  // The address is always pc[sel]; it is only meaningful while imem_re is high.
  assign bus.imem_re                    = issue;
  assign bus.imem_raddr                 = pc_q[sel];
  assign bus.out_instruction            = bus.imem_rdata;
  assign bus.out_instruction_valid_flag = valid_q;
  assign bus.out_thread_index           = thread_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        pc_q[i] <= PC_WIDTH'(RESET_PC);
      end
      last_thread_q <= '1;
      valid_q       <= 1'b0;
      thread_q      <= '0;
    end else begin
      if (!in_stall_flag) begin
        if (any_en) begin
          pc_q[sel]     <= pc_q[sel] + PC_WIDTH'(1);
          last_thread_q <= sel;
          valid_q       <= 1'b1;
          thread_q      <= sel;
        end else begin
          valid_q <= 1'b0;
        end
      end
      // Placed last so a redirect wins over the increment of the same thread.
      if (in_redirect_flag) begin
        pc_q[in_redirect_thread_index] <= in_redirect_pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a synchronous memory model where
// mem[a] = a, so out_instruction reveals the PC used for each fetch.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic [7:0]  mask;
  logic        stall;
  logic        rflag;
  logic [2:0]  rthr;
  logic [15:0] rpc;

  int vectors     = 0;
  int miscompares = 0;

  logic [34:0] exp_q[$];

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk                      (clk),
    .reset                    (reset),
    .in_thread_enable_mask    (mask),
    .in_stall_flag            (stall),
    .in_redirect_flag         (rflag),
    .in_redirect_thread_index (rthr),
    .in_redirect_pc           (rpc),
    .bus                      (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory: data held while imem_re is low
  initial bus.imem_rdata = '0;
  always @(posedge clk) begin
    if (bus.imem_re) bus.imem_rdata <= {16'h0000, bus.imem_raddr};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // comb fetch request for the coming edge
  task automatic check_fetch(input string tag, input logic re, input logic [15:0] addr);
    #1;
    check({tag, "_re"}, 64'(bus.imem_re), 64'(re));
    if (re) check({tag, "_addr"}, 64'(bus.imem_raddr), 64'(addr));
  endtask

  task automatic check_out(input string tag, input logic v, input logic [2:0] t, input logic [31:0] ins);
    check({tag, "_valid"}, 64'(bus.out_instruction_valid_flag), 64'(v));
    if (v) begin
      check({tag, "_thread"}, 64'(bus.out_thread_index), 64'(t));
      check({tag, "_instr"}, 64'(bus.out_instruction), 64'(ins));
    end
  endtask

  logic [34:0] e;

  initial begin
    reset = 1'b1; mask = '0; stall = 1'b0; rflag = 1'b0; rthr = '0; rpc = '0;
    tick();
    tick();
    check("reset_valid", 64'(bus.out_instruction_valid_flag), 64'(0));
    check("reset_thread", 64'(bus.out_thread_index), 64'(0));
    mask = 8'hFF;
    check_fetch("reset_re", 1'b0, 16'h0);

    // full rotation: threads 0..7 twice, PCs 0 then 1
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check_fetch("rot", 1'b1, 16'(i / 8));
      exp_q.push_back({3'(i % 8), 32'(i / 8)});
      tick();
      e = exp_q.pop_front();
      check_out("rot", 1'b1, e[34:32], e[31:0]);
    end

    // two threads alternate
    mask = 8'b0010_0100;
    for (int j = 0; j < 4; j++) begin
      check_fetch("alt", 1'b1, 16'(2 + j / 2));
      tick();
      check_out("alt", 1'b1, (j % 2 == 0) ? 3'd2 : 3'd5, 32'(2 + j / 2));
    end

    // empty mask: idle, PCs untouched
    mask = 8'h00;
    for (int j = 0; j < 3; j++) begin
      check_fetch("idle", 1'b0, 16'h0);
      tick();
      check_out("idle", 1'b0, 3'd0, 32'd0);
    end
    mask = 8'b0010_0100;
    check_fetch("resume2", 1'b1, 16'd4);
    tick();
    check_out("resume2", 1'b1, 3'd2, 32'd4);
    check_fetch("resume5", 1'b1, 16'd4);
    tick();
    check_out("resume5", 1'b1, 3'd5, 32'd4);

    // stall mid-stream
    mask = 8'hFF;
    check_fetch("pre_stall6", 1'b1, 16'd2);
    tick();
    check_out("pre_stall6", 1'b1, 3'd6, 32'd2);
    check_fetch("pre_stall7", 1'b1, 16'd2);
    tick();
    check_out("pre_stall7", 1'b1, 3'd7, 32'd2);
    stall = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check_fetch("stall", 1'b0, 16'h0);
      tick();
      check_out("stall_hold", 1'b1, 3'd7, 32'd2);
    end
    stall = 1'b0;
    check_fetch("post_stall0", 1'b1, 16'd2);
    tick();
    check_out("post_stall0", 1'b1, 3'd0, 32'd2);
    check_fetch("post_stall1", 1'b1, 16'd2);
    tick();
    check_out("post_stall1", 1'b1, 3'd1, 32'd2);
    check_fetch("post_stall2", 1'b1, 16'd5);
    tick();
    check_out("post_stall2", 1'b1, 3'd2, 32'd5);
    check_fetch("post_stall3", 1'b1, 16'd2);
    tick();
    check_out("post_stall3", 1'b1, 3'd3, 32'd2);

    // redirect thread 3 in its own issue cycle
    mask = 8'b0000_1000;
    rflag = 1'b1; rthr = 3'd3; rpc = 16'h0100;
    check_fetch("redir_issue", 1'b1, 16'd3);
    tick();
    rflag = 1'b0;
    check_out("redir_issue", 1'b1, 3'd3, 32'd3);
    check_fetch("redir_new", 1'b1, 16'h0100);
    tick();
    check_out("redir_new", 1'b1, 3'd3, 32'h0100);
    check_fetch("redir_next", 1'b1, 16'h0101);
    tick();
    check_out("redir_next", 1'b1, 3'd3, 32'h0101);

    // redirect during stall
    stall = 1'b1; rflag = 1'b1; rthr = 3'd3; rpc = 16'h0200;
    check_fetch("redir_stall", 1'b0, 16'h0);
    tick();
    rflag = 1'b0;
    check_out("redir_stall_hold", 1'b1, 3'd3, 32'h0101);
    tick();
    stall = 1'b0;
    check_fetch("redir_stall_land", 1'b1, 16'h0200);
    tick();
    check_out("redir_stall_land", 1'b1, 3'd3, 32'h0200);

    // redirect an idle thread to FFFF while thread 3 issues
    rflag = 1'b1; rthr = 3'd5; rpc = 16'hFFFF;
    check_fetch("redir_other", 1'b1, 16'h0201);
    tick();
    rflag = 1'b0;
    check_out("redir_other", 1'b1, 3'd3, 32'h0201);
    mask = 8'b0010_0000;
    check_fetch("wrap_ffff", 1'b1, 16'hFFFF);
    tick();
    check_out("wrap_ffff", 1'b1, 3'd5, 32'h0000_FFFF);
    check_fetch("wrap_0000", 1'b1, 16'h0000);
    tick();
    check_out("wrap_0000", 1'b1, 3'd5, 32'h0);
    check_fetch("wrap_0001", 1'b1, 16'h0001);
    tick();
    check_out("wrap_0001", 1'b1, 3'd5, 32'h1);

    // reset mid-stream squashes and rewinds all PCs
    mask = 8'hFF;
    check_fetch("pre_rst6", 1'b1, 16'd3);
    tick();
    check_out("pre_rst6", 1'b1, 3'd6, 32'd3);
    check_fetch("pre_rst7", 1'b1, 16'd3);
    tick();
    check_out("pre_rst7", 1'b1, 3'd7, 32'd3);
    reset = 1'b1;
    check_fetch("mid_rst", 1'b0, 16'h0);
    tick();
    check("mid_rst_valid", 64'(bus.out_instruction_valid_flag), 64'(0));
    check("mid_rst_thread", 64'(bus.out_thread_index), 64'(0));
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_fetch("post_rst", 1'b1, 16'h0);
      tick();
      check_out("post_rst", 1'b1, 3'(i), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Front stage of the barrel-threaded pipeline. It keeps one program counter per hardware thread and picks the next enabled thread round-robin each cycle. It reads that thread's instruction from a synchronous instruction memory and presents instruction, valid flag and thread index to the decode stage one cycle later. It also accepts per-thread PC redirects from later stages and a pipeline stall.

## Interface

Parameters:
- INSTR_WIDTH, 32, instruction width; matches decode stage.
- THREAD_INDEX_BITS, 3, log2 of thread count (8 threads).
- PC_WIDTH, 16, word-address width of instruction memory.

Ports:
- clk  input  1  pipeline clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- in_thread_enable_mask  input  2**THREAD_INDEX_BITS  bit t=1 makes thread t eligible for issue.
- in_stall_flag  input  1  downstream stall; freezes this stage.
- in_redirect_flag  input  1  load a new PC into one thread.
- in_redirect_thread_index  input  THREAD_INDEX_BITS  thread to redirect.
- in_redirect_pc  input  PC_WIDTH  new PC value.
- imem_raddr  output  PC_WIDTH  instruction memory read address.
- imem_re  output  1  instruction memory read enable.
- imem_rdata  input  INSTR_WIDTH  read data, valid the cycle after imem_re. Held by the memory while imem_re=0.
- out_instruction_valid_flag  output  1  to decode in_instruction_valid_flag.
- out_instruction  output  INSTR_WIDTH  to decode in_instruction; wired from imem_rdata.
- out_thread_index  output  THREAD_INDEX_BITS  to decode in_thread_index.

## Operation

- State:
  - pc[0..N-1], PC_WIDTH each.
  - last_thread, THREAD_INDEX_BITS: the thread issued most recently.
  - Output registers: valid_q and thread_q.
- Selection (combinational):
  - Candidate order is last_thread+1, last_thread+2, … modulo N, ending at last_thread itself.
  - The first candidate with its mask bit set is sel.
  - any_en = OR of the mask.
- Issue cycle (reset=0, in_stall_flag=0, any_en=1):
  - imem_re=1 and imem_raddr=pc[sel].
  - pc[sel] ← pc[sel]+1, wrapping from 2**PC_WIDTH−1 to 0.
  - last_thread ← sel, valid_q ← 1, thread_q ← sel.
- Idle cycle (no stall, any_en=0):
  - imem_re=0 and valid_q ← 0.
  - last_thread and all PCs are unchanged.
- Stall cycle:
  - imem_re=0.
  - valid_q, thread_q, last_thread and all PCs (except by redirect) hold.
  - The memory holds rdata, so decode sees a stable instruction.
- Redirect:
  - Sampled every cycle, including stalled cycles.
  - pc[in_redirect_thread_index] ← in_redirect_pc.
  - If the same thread issues in that cycle, the issue uses the old PC and the redirect overrides the +1 increment.
  - A redirect does not squash an instruction already in out_*; later stages discard it.
- Mask changes take effect on the next selection. A thread disabled while in flight still delivers its registered instruction.
- imem_raddr is don't-care when imem_re=0. Drive pc[sel] to avoid extra muxing.

## Timing

- Fetch latency is 1 cycle. Issue at cycle n gives out_* valid at cycle n+1, and out_instruction = mem[pc] of cycle n.
- Throughput is one instruction per non-stalled cycle. With all 8 threads enabled, each thread issues every 8th cycle.
- Reset (synchronous, any cycle):
  - All PCs ← 0, last_thread ← N−1 (so thread 0 is first after reset), valid_q ← 0, thread_q ← 0.
  - imem_re=0 during reset cycles.
- Reset mid-operation squashes the in-flight fetch: valid=0 the cycle after reset is sampled.
- Reset has priority over stall, which has priority over issue. Redirect applies under stall but not under reset.
- First issue is in the cycle reset is deasserted, so the first valid output appears one cycle later.

## Structure

- Shared package pipeline_pkg holds:
  - THREAD_INDEX_BITS, INSTR_WIDTH, PC_WIDTH defaults shared with decode_stage.
  - Opcode constants 6'b000001 (increment), 6'b000010 (load), 6'b000011 (store).
  - RESET_PC = 0.
- Sub-module round_robin_arbiter(N): inputs request mask and last-grant index, outputs grant index and any-grant. Purely combinational and reusable by the writeback arbiter.
- PC array is a flop array inside fetch_stage, not a RAM: it needs one read, one increment write and one redirect write per cycle.

## Test plan

- Reset then mask=8'hFF, no stall, mem[a]=a:
  - out_thread_index is 0,1,…,7,0,… from cycle 1 after reset.
  - out_instruction is 0 for the first 8 outputs, then 1 for the next 8.
- Mask=8'b0010_0100:
  - Threads alternate 2,5,2,5.
  - A mask of 0 for 3 cycles gives valid=0 for 3 cycles with PCs unchanged. Re-enabling resumes from the correct PCs.
- Stall for 4 cycles mid-stream:
  - out_* hold their exact value and imem_re=0 throughout.
  - After release, the sequence continues with no skipped or duplicated thread/PC.
- Redirect thread 3 to 16'h0100 on the cycle thread 3 issues, then again during a stall:
  - Thread 3's next fetch address is 16'h0100 and the following one 16'h0101.
  - The stalled-cycle redirect also lands.
- Single thread enabled with its PC set to 16'hFFFF by redirect:
  - Fetch addresses FFFF, 0000, 0001.
- Assert reset for one cycle mid-stream:
  - valid=0 next cycle and all PCs return to 0.
  - The first post-reset output is thread 0 at address 0.
